// File: rtl/message_rx.sv
// P-code correlating receiver: integrates each message bit over PCODE_LEN*PCODE_REPEATS
// samples, hard-slices it, and assembles PPS-aligned frames into a readable buffer plus UTC fields.
module message_rx #(
  parameter int PCODE_LEN     = 40920,
  parameter int PCODE_REPEATS = 10,
  parameter int MESSAGE_LEN   = 120,
  parameter int ACC_W         = 32
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             rx_enable_i,
  input  logic             pps_in_i,
  input  logic             adc_valid_i,
  input  logic [11:0]      adc_data_i,
  input  logic             pcode_chip_i,
  output logic [15:0]      chip_idx_o,
  output logic             bit_valid_o,
  output logic             bit_data_o,
  output logic [ACC_W-1:0] bit_metric_o,
  output logic             frame_done_o,
  output logic             frame_abort_o,
  input  logic [2:0]       rd_addr_i,
  output logic [31:0]      rd_data_o,
  output logic             utc_valid_o,
  output logic [7:0]       utc_year_o,
  output logic [3:0]       utc_month_o,
  output logic [4:0]       utc_day_o,
  output logic [5:0]       utc_second_o,
  output logic [5:0]       utc_minute_o,
  output logic [4:0]       utc_hour_o
);

  localparam int RW = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1;
  localparam int MO_O = 8, DY_O = 12, SE_O = 17, MI_O = 23, HR_O = 29;

  typedef enum logic {IDLE, ACC} state_e;
  state_e state_q, state_d;

  logic pps_meta_q, pps_sync_q, pps_dly_q, pps_p_q;

  logic signed [ACC_W-1:0] acc_q, acc_d, metric_q, metric_d;
  logic [15:0]         chip_q, chip_d;
  logic [RW-1:0]       rep_q, rep_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic [255:0]        shadow_q, shadow_d, shadow_new;
  logic [7:0][31:0]    rbuf_q, rbuf_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic bit_valid_q, bit_valid_d, bit_data_q, bit_data_d;
  logic frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;
  logic [7:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d, hour_q, hour_d;
  logic [5:0] sec_q, sec_d, min_q, min_d;

  logic signed [ACC_W-1:0] samp_ext, samp, acc_sum;
  logic chip_last, rep_last, bit_end, frame_end, in_acc;

  assign samp_ext  = ACC_W'($signed(adc_data_i));
  assign samp      = pcode_chip_i ? samp_ext : -samp_ext;
  assign acc_sum   = acc_q + samp;
  assign in_acc    = (state_q == ACC) && rx_enable_i;
  assign chip_last = (chip_q == 16'(PCODE_LEN - 1));
  assign rep_last  = (rep_q == RW'(PCODE_REPEATS - 1));
  assign bit_end   = in_acc && adc_valid_i && chip_last && rep_last;
  assign frame_end = bit_end && (bcnt_q == 8'(MESSAGE_LEN - 1));

  always_comb begin
    shadow_new = shadow_q;
    shadow_new[bcnt_q] = acc_sum[ACC_W-1];
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pps_p_q && rx_enable_i) state_d = ACC;
      ACC: begin
        if (!rx_enable_i)              state_d = IDLE;
        else if (frame_end && !pps_p_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q; chip_d = chip_q; rep_d = rep_q; bcnt_d = bcnt_q;
    shadow_d = shadow_q; rbuf_d = rbuf_q; metric_d = metric_q;
    bit_valid_d = 1'b0; bit_data_d = bit_data_q;
    frame_done_d = 1'b0; frame_abort_d = 1'b0;
    year_d = year_q; month_d = month_q; day_d = day_q;
    sec_d = sec_q; min_d = min_q; hour_d = hour_q;
    if (state_q == ACC && !rx_enable_i) begin
      acc_d = '0; chip_d = '0; rep_d = '0; bcnt_d = '0;
    end else if (in_acc) begin
      // a PPS discards its own sample unless that sample closes a bit
      if (adc_valid_i && (!pps_p_q || bit_end)) begin
        acc_d = bit_end ? '0 : acc_sum;
        if (chip_last) begin
          chip_d = '0;
          rep_d  = rep_last ? '0 : rep_q + RW'(1);
        end else begin
          chip_d = chip_q + 16'd1;
        end
        if (bit_end) begin
          bit_valid_d = 1'b1;
          bit_data_d  = acc_sum[ACC_W-1];
          metric_d    = acc_sum;
          shadow_d    = shadow_new;
          bcnt_d      = bcnt_q + 8'd1;
          if (frame_end) begin
            bcnt_d       = '0;
            rbuf_d       = shadow_new;
            frame_done_d = 1'b1;
            for (int i = 0; i < 8; i++) year_d[7-i]  = shadow_new[i];
            for (int i = 0; i < 4; i++) month_d[3-i] = shadow_new[MO_O+i];
            for (int i = 0; i < 5; i++) day_d[4-i]   = shadow_new[DY_O+i];
            for (int i = 0; i < 6; i++) sec_d[5-i]   = shadow_new[SE_O+i];
            for (int i = 0; i < 6; i++) min_d[5-i]   = shadow_new[MI_O+i];
            for (int i = 0; i < 5; i++) hour_d[4-i]  = shadow_new[HR_O+i];
          end
        end
      end
      if (pps_p_q) begin
        frame_abort_d = !bit_end && (bcnt_q != '0 || chip_q != '0 || rep_q != '0);
        acc_d = '0; chip_d = '0; rep_d = '0; bcnt_d = '0;
      end
    end else if (state_q == IDLE && pps_p_q && rx_enable_i) begin
      acc_d = '0; chip_d = '0; rep_d = '0; bcnt_d = '0;
    end
    // reading through the next-state buffer makes a copy-cycle read see new data
    rd_data_d = rbuf_d[rd_addr_i];
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      pps_meta_q <= 1'b0; pps_sync_q <= 1'b0; pps_dly_q <= 1'b0; pps_p_q <= 1'b0;
      acc_q <= '0; chip_q <= '0; rep_q <= '0; bcnt_q <= '0;
      shadow_q <= '0; rbuf_q <= '0; rd_data_q <= '0; metric_q <= '0;
      bit_valid_q <= 1'b0; bit_data_q <= 1'b0;
      frame_done_q <= 1'b0; frame_abort_q <= 1'b0;
      year_q <= '0; month_q <= '0; day_q <= '0;
      sec_q <= '0; min_q <= '0; hour_q <= '0;
    end else begin
      pps_meta_q <= pps_in_i;
      pps_sync_q <= pps_meta_q;
      pps_dly_q  <= pps_sync_q;
      pps_p_q    <= pps_sync_q & ~pps_dly_q;
      acc_q <= acc_d; chip_q <= chip_d; rep_q <= rep_d; bcnt_q <= bcnt_d;
      shadow_q <= shadow_d; rbuf_q <= rbuf_d; rd_data_q <= rd_data_d; metric_q <= metric_d;
      bit_valid_q <= bit_valid_d; bit_data_q <= bit_data_d;
      frame_done_q <= frame_done_d; frame_abort_q <= frame_abort_d;
      year_q <= year_d; month_q <= month_d; day_q <= day_d;
      sec_q <= sec_d; min_q <= min_d; hour_q <= hour_d;
    end
  end

  assign chip_idx_o    = chip_q;
  assign bit_valid_o   = bit_valid_q;
  assign bit_data_o    = bit_data_q;
  assign bit_metric_o  = metric_q;
  assign frame_done_o  = frame_done_q;
  assign utc_valid_o   = frame_done_q;
  assign frame_abort_o = frame_abort_q;
  assign rd_data_o     = rd_data_q;
  assign utc_year_o    = year_q;
  assign utc_month_o   = month_q;
  assign utc_day_o     = day_q;
  assign utc_second_o  = sec_q;
  assign utc_minute_o  = min_q;
  assign utc_hour_o    = hour_q;

endmodule

// File: tb/tb_message_rx.sv
// Randomized bench for message_rx: bits are scored against sums computed from the drawn samples,
// frames against buffer words and UTC fields built from the bit list.
module tb_message_rx;
  localparam int PL = 4, PR = 2, ML = 40, SPB = PL * PR;

  logic gclk = 1'b0, grst_n = 1'b0, rx_en = 1'b0, pps = 1'b0, adc_valid = 1'b0, pcode = 1'b0;
  logic [11:0] adc_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] chip_idx;
  logic        bit_valid, bit_data, frame_done, frame_abort, utc_valid;
  logic [31:0] bit_metric, rd_data;
  logic [7:0]  utc_year;
  logic [3:0]  utc_month;
  logic [4:0]  utc_day, utc_hour;
  logic [5:0]  utc_second, utc_minute;

  message_rx #(.PCODE_LEN(PL), .PCODE_REPEATS(PR), .MESSAGE_LEN(ML), .ACC_W(32)) dut (
    .gclk(gclk), .grst_n(grst_n), .rx_enable_i(rx_en), .pps_in_i(pps),
    .adc_valid_i(adc_valid), .adc_data_i(adc_data), .pcode_chip_i(pcode),
    .chip_idx_o(chip_idx), .bit_valid_o(bit_valid), .bit_data_o(bit_data),
    .bit_metric_o(bit_metric), .frame_done_o(frame_done), .frame_abort_o(frame_abort),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .utc_valid_o(utc_valid),
    .utc_year_o(utc_year), .utc_month_o(utc_month), .utc_day_o(utc_day),
    .utc_second_o(utc_second), .utc_minute_o(utc_minute), .utc_hour_o(utc_hour));

  always #5 gclk = ~gclk;

  int ntests = 0, nfail = 0;
  int n_bv = 0, n_fd = 0, n_ab = 0, n_utc = 0, last_met = 0;
  bit last_bit = 1'b0;
  bit exp_bit[$];
  int exp_met[$];
  int log_met[$];
  int bs_d[SPB];
  bit bs_c[SPB];
  bit fb[ML];

  // scoreboard: every bit decision must match the oldest expected bit
  always @(posedge gclk) begin
    #1;
    if (bit_valid) begin
      n_bv++; last_bit = bit_data; last_met = $signed(bit_metric); log_met.push_back(last_met);
      ntests++;
      if (exp_bit.size() == 0) begin
        nfail++; $display("FAIL unexpected_bit: got bit=%0d metric=%0d, expected none", bit_data, last_met);
      end else begin
        bit eb; int em;
        eb = exp_bit.pop_front(); em = exp_met.pop_front();
        if ({bit_data, bit_metric} !== {eb, 32'(em)}) begin
          nfail++; $display("FAIL bit_decision: got bit=%0d metric=%0d, expected bit=%0d metric=%0d",
                            bit_data, last_met, eb, em);
        end
      end
    end
    if (frame_done)  n_fd++;
    if (frame_abort) n_ab++;
    if (utc_valid)   n_utc++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    @(negedge gclk); adc_valid = 1'b0;
    repeat (n - 1) @(negedge gclk);
  endtask

  task automatic do_pps();
    @(negedge gclk); adc_valid = 1'b0; pps = 1'b1;
    repeat (2) @(negedge gclk);
    pps = 1'b0;
    repeat (4) @(negedge gclk);
  endtask

  task automatic gen_bit(input int want);
    int s;
    while (1) begin
      s = 0;
      for (int i = 0; i < SPB; i++) begin
        bs_d[i] = int'($urandom_range(4095, 0)) - 2048;
        bs_c[i] = 1'($urandom_range(1, 0));
        s += bs_c[i] ? bs_d[i] : -bs_d[i];
      end
      if ((want == 1 && s > 0) || (want == 0 && s < 0))
        for (int i = 0; i < SPB; i++) bs_c[i] = ~bs_c[i];
      if (want < 0 || s != 0 || want == 0) break;
    end
  endtask

  task automatic play_bit(input bit gap, input bit push);
    int s = 0;
    for (int i = 0; i < SPB; i++) s += bs_c[i] ? bs_d[i] : -bs_d[i];
    if (push) begin exp_bit.push_back(s < 0); exp_met.push_back(s); end
    for (int i = 0; i < SPB; i++) begin
      @(negedge gclk); adc_valid = 1'b1; adc_data = 12'(bs_d[i]); pcode = bs_c[i];
      if (gap) begin @(negedge gclk); adc_valid = 1'b0; end
    end
  endtask

  task automatic play_bits(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin gen_bit(int'(fb[k])); play_bit(gap, 1'b1); end
  endtask

  task automatic play_const(input int d, input bit c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge gclk); adc_valid = 1'b1; adc_data = 12'(d); pcode = c;
    end
  endtask

  function automatic void set_field(input int off, input int w, input int v);
    for (int i = 0; i < w; i++) fb[off + i] = 1'((v >> (w - 1 - i)) & 1);
  endfunction

  function automatic int get_field(input int off, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(fb[off + i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w = '0;
    for (int k = 0; k < ML; k++) if (k / 32 == a) w[k % 32] = fb[k];
    return w;
  endfunction

  task automatic test_reset();
    grst_n = 1'b0; rx_en = 1'b0;
    repeat (3) @(negedge gclk);
    @(posedge gclk); #1;
    ntests++;
    if ({bit_valid, bit_data, bit_metric, frame_done, frame_abort, utc_valid, utc_year, utc_month,
         utc_day, utc_second, utc_minute, utc_hour, chip_idx, rd_data} !== '0) begin
      nfail++; $display("FAIL reset_outputs: got nonzero outputs chip_idx=%0d metric=%0d, expected all 0",
                        chip_idx, bit_metric);
    end
    @(negedge gclk); grst_n = 1'b1;
    for (int a = 0; a < 3; a++) begin
      @(negedge gclk); rd_addr = 3'(a);
      @(posedge gclk); #1;
      ntests++;
      if (rd_data !== 32'h0) begin
        nfail++; $display("FAIL reset_rd_data: addr %0d got %h, expected 0", a, rd_data);
      end
    end
  endtask

  task automatic test_single_bit();
    rx_en = 1'b1; do_pps();
    exp_bit.push_back(1'b0); exp_met.push_back(800);
    play_const(100, 1'b1, SPB); idle(3);
    ntests++;
    if (last_bit !== 1'b0 || last_met != 800) begin
      nfail++; $display("FAIL single_bit_pos: got bit=%0d metric=%0d, expected 0/800", last_bit, last_met);
    end
    exp_bit.push_back(1'b1); exp_met.push_back(-800);
    play_const(100, 1'b0, SPB); idle(3);
    ntests++;
    if (last_bit !== 1'b1 || last_met != -800) begin
      nfail++; $display("FAIL single_bit_neg: got bit=%0d metric=%0d, expected 1/-800", last_bit, last_met);
    end
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_frame();
    for (int f = 0; f < 2; f++) begin
      int fd0 = n_fd, ut0 = n_utc, ey, emo, ed, es, emi, eh;
      if (f == 0) begin
        ey = 25; emo = 6; ed = 14; es = 30; emi = 45; eh = 12;
        set_field(0, 8, ey); set_field(8, 4, emo); set_field(12, 5, ed);
        set_field(17, 6, es); set_field(23, 6, emi); set_field(29, 5, eh);
        for (int k = 34; k < ML; k++) fb[k] = 1'b1;
      end else begin
        for (int k = 0; k < ML; k++) fb[k] = 1'($urandom_range(1, 0));
        ey = get_field(0, 8); emo = get_field(8, 4); ed = get_field(12, 5);
        es = get_field(17, 6); emi = get_field(23, 6); eh = get_field(29, 5);
      end
      rx_en = 1'b1; do_pps();
      play_bits(ML, 1'b0); idle(3);
      ntests++;
      if (n_fd - fd0 != 1 || n_utc - ut0 != 1) begin
        nfail++; $display("FAIL frame_done: frame %0d got done=%0d utc_valid=%0d pulses, expected 1/1",
                          f, n_fd - fd0, n_utc - ut0);
      end
      ntests++;
      if ({utc_year, utc_month, utc_day, utc_second, utc_minute, utc_hour} !==
          {8'(ey), 4'(emo), 5'(ed), 6'(es), 6'(emi), 5'(eh)}) begin
        nfail++; $display("FAIL utc_fields: frame %0d got %0d/%0d/%0d %0d:%0d:%0d, expected %0d/%0d/%0d %0d:%0d:%0d",
                          f, utc_year, utc_month, utc_day, utc_hour, utc_minute, utc_second,
                          ey, emo, ed, eh, emi, es);
      end
      for (int a = 0; a < 3; a++) begin
        @(negedge gclk); rd_addr = 3'(a);
        @(posedge gclk); #1;
        ntests++;
        if (rd_data !== exp_word(a)) begin
          nfail++; $display("FAIL frame_rd_data: frame %0d addr %0d got %h, expected %h", f, a, rd_data, exp_word(a));
        end
      end
      // frame ended on its own: further samples must produce nothing
      begin
        int bv0 = n_bv;
        gen_bit(-1); play_bit(1'b0, 1'b0); idle(3);
        ntests++;
        if (n_bv != bv0) begin
          nfail++; $display("FAIL frame_idle: got %0d bits after frame end, expected 0", n_bv - bv0);
        end
      end
    end
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_extremes();
    rx_en = 1'b1; do_pps();
    exp_bit.push_back(1'b0); exp_met.push_back(0);
    play_const(100, 1'b1, SPB / 2); play_const(100, 1'b0, SPB / 2); idle(3);
    ntests++;
    if (last_bit !== 1'b0 || last_met != 0) begin
      nfail++; $display("FAIL zero_sum: got bit=%0d metric=%0d, expected 0/0", last_bit, last_met);
    end
    exp_bit.push_back(1'b1); exp_met.push_back(-2048 * SPB);
    play_const(-2048, 1'b1, SPB); idle(3);
    ntests++;
    if (last_bit !== 1'b1 || last_met != -16384) begin
      nfail++; $display("FAIL min_sample: got bit=%0d metric=%0d, expected 1/-16384", last_bit, last_met);
    end
    exp_bit.push_back(1'b0); exp_met.push_back(2048 * SPB);
    play_const(-2048, 1'b0, SPB); idle(3);
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_abort();
    logic [31:0] prev [3];
    int ab0, fd0;
    for (int a = 0; a < 3; a++) prev[a] = exp_word(a);
    for (int k = 0; k < ML; k++) fb[k] = 1'($urandom_range(1, 0));
    rx_en = 1'b1; do_pps();
    play_bits(13, 1'b0); idle(2);
    ab0 = n_ab; fd0 = n_fd;
    do_pps(); idle(2);
    ntests++;
    if (n_ab - ab0 != 1 || n_fd != fd0) begin
      nfail++; $display("FAIL abort_pulse: got abort=%0d done=%0d pulses, expected 1/0", n_ab - ab0, n_fd - fd0);
    end
    for (int a = 0; a < 3; a++) begin
      @(negedge gclk); rd_addr = 3'(a);
      @(posedge gclk); #1;
      ntests++;
      if (rd_data !== prev[a]) begin
        nfail++; $display("FAIL abort_buffer: addr %0d got %h, expected %h", a, rd_data, prev[a]);
      end
    end
    for (int k = 0; k < ML; k++) fb[k] = 1'($urandom_range(1, 0));
    play_bits(ML, 1'b1); idle(3);
    ntests++;
    if (n_fd - fd0 != 1 || n_ab - ab0 != 1) begin
      nfail++; $display("FAIL abort_restart: got done=%0d abort=%0d pulses, expected 1/1", n_fd - fd0, n_ab - ab0);
    end
    for (int a = 0; a < 2; a++) begin
      @(negedge gclk); rd_addr = 3'(a);
      @(posedge gclk); #1;
      ntests++;
      if (rd_data !== exp_word(a)) begin
        nfail++; $display("FAIL restart_buffer: addr %0d got %h, expected %h", a, rd_data, exp_word(a));
      end
    end
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_disable();
    int bv0, ab0;
    rx_en = 1'b1; do_pps();
    gen_bit(-1);
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk); adc_valid = 1'b1; adc_data = 12'(bs_d[i]); pcode = bs_c[i];
    end
    idle(2);
    ntests++;
    if (chip_idx !== 16'd1) begin
      nfail++; $display("FAIL chip_idx: got %0d after 5 samples, expected 1", chip_idx);
    end
    bv0 = n_bv; ab0 = n_ab;
    rx_en = 1'b0; idle(2);
    ntests++;
    if (chip_idx !== 16'd0) begin
      nfail++; $display("FAIL disable_clear: chip_idx got %0d, expected 0", chip_idx);
    end
    rx_en = 1'b1;
    gen_bit(-1); play_bit(1'b0, 1'b0); idle(3);
    rx_en = 1'b0; do_pps(); rx_en = 1'b1;
    gen_bit(-1); play_bit(1'b0, 1'b0); idle(3);
    ntests++;
    if (n_bv != bv0 || n_ab != ab0) begin
      nfail++; $display("FAIL disable_idle: got %0d bits %0d aborts, expected 0/0", n_bv - bv0, n_ab - ab0);
    end
    do_pps();
    gen_bit(-1); play_bit(1'b0, 1'b1); idle(3);
    ntests++;
    if (n_bv - bv0 != 1 || exp_bit.size() != 0) begin
      nfail++; $display("FAIL disable_resume: got %0d bits (%0d pending), expected 1/0", n_bv - bv0, exp_bit.size());
    end
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < ML; k++) fb[k] = 1'($urandom_range(1, 0));
    rx_en = 1'b1; do_pps();
    play_bits(20, 1'b0);
    gen_bit(-1);
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk); adc_valid = 1'b1; adc_data = 12'(bs_d[i]); pcode = bs_c[i];
    end
    @(negedge gclk); adc_valid = 1'b0; grst_n = 1'b0;
    @(posedge gclk); #1;
    ntests++;
    if ({bit_valid, bit_data, bit_metric, frame_done, frame_abort, utc_valid, utc_year, utc_month,
         utc_day, utc_second, utc_minute, utc_hour, chip_idx, rd_data} !== '0) begin
      nfail++; $display("FAIL reset_mid: got chip_idx=%0d metric=%0d rd=%h, expected all 0", chip_idx, bit_metric, rd_data);
    end
    @(negedge gclk); grst_n = 1'b1;
    for (int a = 0; a < 2; a++) begin
      @(negedge gclk); rd_addr = 3'(a);
      @(posedge gclk); #1;
      ntests++;
      if (rd_data !== 32'h0) begin
        nfail++; $display("FAIL reset_mid_buffer: addr %0d got %h, expected 0", a, rd_data);
      end
    end
    rx_en = 1'b0; idle(2);
  endtask

  task automatic test_gaps();
    int gd [3*SPB];
    bit gc [3*SPB];
    int base_a, base_b;
    for (int i = 0; i < 3 * SPB; i++) begin
      gd[i] = int'($urandom_range(4095, 0)) - 2048; gc[i] = 1'($urandom_range(1, 0));
    end
    for (int run = 0; run < 2; run++) begin
      if (run == 0) base_a = log_met.size(); else base_b = log_met.size();
      rx_en = 1'b1; do_pps();
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < SPB; i++) begin bs_d[i] = gd[b*SPB+i]; bs_c[i] = gc[b*SPB+i]; end
        play_bit(run == 1, 1'b1);
      end
      idle(3); rx_en = 1'b0; idle(2);
    end
    ntests++;
    if (log_met.size() - base_b != 3 || base_b - base_a != 3) begin
      nfail++; $display("FAIL gaps_count: got %0d/%0d bits, expected 3/3", base_b - base_a, log_met.size() - base_b);
    end else begin
      for (int b = 0; b < 3; b++) begin
        ntests++;
        if (log_met[base_b + b] != log_met[base_a + b]) begin
          nfail++; $display("FAIL gaps_metric: bit %0d got %0d with gaps, expected %0d", b,
                            log_met[base_b + b], log_met[base_a + b]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_frame();
    test_extremes();
    test_abort();
    test_disable();
    test_reset_mid();
    test_gaps();
    ntests++;
    if (exp_bit.size() != 0) begin
      nfail++; $display("FAIL missing_bits: got %0d undelivered decisions, expected 0", exp_bit.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
